addsub_pipe: RTL
================

Name: addsub_pipe

Overview:
- Parametrised, pipelined add/subtract unit; next generation of the 16-bit ripple-carry adder used in the CPU datapath.
- Splits a WIDTH-bit operation into STAGES carry-chained segments, one segment per pipeline stage, to shorten the critical path.
- Adds carry-in, a subtract mode, status flags and a valid/ready handshake with backpressure.
- Sits between operand fetch and the ALU result mux.

Parameters:
- WIDTH, 16: operand/result width in bits. WIDTH % STAGES must be 0; otherwise elaboration fails.
- STAGES, 4: pipeline depth and segment count; segment width SEG = WIDTH/STAGES. Legal range is 1..WIDTH.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  unit accepts a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in (add) / borrow-in (sub).
- op  in  1  0 = add, 1 = subtract.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH  result.
- cout  out  1  carry-out of MSB (sub: 1 = no borrow).
- ovf  out  1  signed two's-complement overflow.
- zero  out  1  sum == 0.
- neg  out  1  sum[WIDTH-1].

Behaviour:
- Reset (rst=1 at clk edge): clear all stage valid bits; out_valid=0; sum, cout, ovf, zero, neg = 0. Reset takes priority over every other input. In-flight beats are discarded and produce no output. in_ready=1 in the cycle after reset.
- Operation:
  - add: result = a + b + cin.
  - sub: result = a + ~b + ~cin, i.e. a − b − cin.
  - cout is bit WIDTH of the (WIDTH+1)-bit internal sum.
  - ovf = (A_msb == B'_msb) && (sum_msb != A_msb), where B' is the inverted b for sub.
- Pipeline:
  - Stage k (k = 0..STAGES−1) adds bits [k*SEG +: SEG] of A and B' plus the carry registered from stage k−1. Stage 0 uses the effective cin.
  - Each stage register holds: the not-yet-added upper operand bits, the completed lower sum bits, the carry, the A/B' MSBs, and a valid bit.
  - Flags are computed from the final stage output and registered together with sum.
- Latency: a beat accepted at edge N appears with out_valid=1 after edge N+STAGES, with no stall. Throughput is 1 beat/cycle.
- Handshake:
  - A beat is accepted when in_valid && in_ready at a clock edge.
  - A result transfers when out_valid && out_ready.
  - stall = out_valid && !out_ready. in_ready = !stall (combinational).
  - While stalled, all stage registers and outputs hold, including bubbles. No beat is dropped or duplicated, and order is preserved.
  - When not stalled, the pipeline advances every cycle. Invalid entries (bubbles) advance as valid=0.
  - out_valid stays high and sum/flags stay stable until the transfer completes.
- Boundaries:
  - in_valid=0: bubbles enter; out_valid falls after the last result drains.
  - Accept and output transfer in the same cycle are allowed, and required for full throughput.
  - STAGES=1: single registered adder with 1-cycle latency.
  - a, b, cin and op are sampled only on acceptance. Changes while in_ready=0 have no effect.
  - Arithmetic wraps modulo 2^WIDTH; the overflow information appears only in cout/ovf.

Test Plan:
- WIDTH=16, STAGES=4, out_ready=1, add a=10, b=9, cin=0 → 4 cycles later: sum=19, cout=0, ovf=0, zero=0, neg=0.
- Add a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1, zero=1. Add a=0x7FFF, b=1 → sum=0x8000, ovf=1, neg=1, cout=0. Carry must ripple across all 4 segments.
- Sub a=20, b=9, cin=0 → sum=11, cout=1. Sub a=9, b=20 → sum=0xFFF5, cout=0, neg=1. Sub a=0x8000, b=1 → sum=0x7FFF, ovf=1. Add a=5, b=5, cin=1 → 11.
- Stream 8 back-to-back add beats (a=i, b=100, i=0..7); hold out_ready=0 for 3 cycles starting when the first result appears → in_ready=0 during the stall; all 8 results 100..107 delivered in order, each exactly once.
- Issue 3 beats, assert rst for 1 cycle while they are in flight → out_valid=0 with all outputs 0 next cycle; none of the 3 results ever appears; a new beat 1+1 yields 2 after 4 cycles.
- Re-run scenarios 1–3 with WIDTH=32, STAGES=8 and WIDTH=8, STAGES=1 → results compared against a behavioural (WIDTH+1)-bit model; latency equals STAGES.

Source files
------------

// File: rtl/addsub_pipe.sv
// Pipelined add/subtract unit. WIDTH bits are split into STAGES carry-chained segments.
// Each pipeline stage adds one segment, and the final stage registers the result with its flags.
module addsub_pipe #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int unsigned SEG  = WIDTH / STAGES;
  localparam int unsigned LAST = STAGES - 1;

  if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_params
    $error("addsub_pipe: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH");
  end

  // Stage register k: segments below k already summed in res, A bits above; B' kept whole.
  logic [WIDTH-1:0] res_q [STAGES];
  logic [WIDTH-1:0] res_d [STAGES];
  logic [WIDTH-1:0] opb_q [STAGES];
  logic [WIDTH-1:0] opb_d [STAGES];
  logic [STAGES-1:0] c_q, c_d;
  logic [STAGES-1:0] v_q, v_d;

  logic [SEG:0]     seg_sum [STAGES];
  logic [WIDTH-1:0] adv_res [STAGES];

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;

  logic stall;

  always_comb begin
    stall    = out_valid_q && !out_ready;
    in_ready = !stall;
  end

  always_comb begin : p_segment_add
    for (int unsigned k = 0; k < STAGES; k++) begin
      seg_sum[k] = {1'b0, res_q[k][k*SEG +: SEG]}
                 + {1'b0, opb_q[k][k*SEG +: SEG]}
                 + {{SEG{1'b0}}, c_q[k]};
      adv_res[k] = res_q[k];
      adv_res[k][k*SEG +: SEG] = seg_sum[k][SEG-1:0];
    end
  end

  always_comb begin : p_next
    res_d       = res_q;
    opb_d       = opb_q;
    c_d         = c_q;
    v_d         = v_q;
    out_valid_d = out_valid_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    zero_d      = zero_q;
    neg_d       = neg_q;
    if (!stall) begin
      v_d[0]   = in_valid;
      res_d[0] = a;
      opb_d[0] = op ? ~b : b;
      c_d[0]   = op ? ~cin : cin;
      for (int unsigned k = 1; k < STAGES; k++) begin
        v_d[k]   = v_q[k-1];
        res_d[k] = adv_res[k-1];
        opb_d[k] = opb_q[k-1];
        c_d[k]   = seg_sum[k-1][SEG];
      end
      // The top segment of the last stage still holds the raw A and B' MSBs.
      out_valid_d = v_q[LAST];
      sum_d       = adv_res[LAST];
      cout_d      = seg_sum[LAST][SEG];
      ovf_d       = (res_q[LAST][WIDTH-1] == opb_q[LAST][WIDTH-1])
                 && (adv_res[LAST][WIDTH-1] != res_q[LAST][WIDTH-1]);
      zero_d      = (adv_res[LAST] == '0);
      neg_d       = adv_res[LAST][WIDTH-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_q       <= '{default: '0};
      opb_q       <= '{default: '0};
      c_q         <= '0;
      v_q         <= '0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
    end else begin
      res_q       <= res_d;
      opb_q       <= opb_d;
      c_q         <= c_d;
      v_q         <= v_d;
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
      neg_q       <= neg_d;
    end
  end

  always_comb begin
    out_valid = out_valid_q;
    sum       = sum_q;
    cout      = cout_q;
    ovf       = ovf_q;
    zero      = zero_q;
    neg       = neg_q;
  end

endmodule
